// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes and execute-unit state.
// Imported by both the ALU decoder and the execute unit.
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_MUL = 4'b1000;

   typedef enum logic {
      IDLE,
      MUL_RUN
   } state_e;

endpackage

// File: rtl/alu_exec_unit_mul.sv
// Iterative shift-add multiplier: one bit of op_b per step.
// Produces the low XLEN bits of op_a * op_b.
module seq_multiplier #(
   parameter int XLEN      = 32,
   parameter int MUL_STEPS = XLEN
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            run,
   input  logic            flush,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            done,
   output logic [XLEN-1:0] product
);

   localparam int CW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;

   logic [XLEN-1:0] mcand_q;
   logic [XLEN-1:0] mplier_q;
   logic [XLEN-1:0] acc_q;
   logic [CW-1:0]   count_q;
   logic [XLEN-1:0] addend;

   assign addend = mplier_q[0] ? mcand_q : '0;

   // Accumulator value after the current step, so the last
   // step is folded into the product on the done edge.
   assign product = acc_q + addend;
   assign done    = run && !flush
                 && (count_q == CW'(MUL_STEPS - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         count_q  <= '0;
      end else if (flush) begin
         acc_q    <= '0;
         count_q  <= '0;
      end else if (start) begin
         mcand_q  <= op_a;
         mplier_q <= op_b;
         acc_q    <= '0;
         count_q  <= '0;
      end else if (run) begin
         acc_q    <= product;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         count_q  <= count_q + 1'b1;
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops plus a
// multi-cycle MUL that stalls the pipeline while it runs.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int MUL_STEPS = XLEN
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_ctrl,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            out_valid,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal_op,
   output logic            stall
);

   state_e          state_q;
   state_e          state_d;
   logic            accept;
   logic            is_mul;
   logic            mul_start;
   logic            mul_done;
   logic [XLEN-1:0] mul_prod;
   logic [XLEN-1:0] alu_res;
   logic            alu_ill;

   assign is_mul    = (alu_ctrl == ALU_MUL);
   assign accept    = in_valid && in_ready && !flush;
   assign mul_start = accept && is_mul;

   seq_multiplier #(
      .XLEN      (XLEN),
      .MUL_STEPS (MUL_STEPS)
   ) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .run     (state_q == MUL_RUN),
      .flush   (flush),
      .op_a    (op_a),
      .op_b    (op_b),
      .done    (mul_done),
      .product (mul_prod)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (mul_start) state_d = MUL_RUN;
         MUL_RUN: if (flush || mul_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == IDLE);
      stall    = (state_q != IDLE);
   end

   always_comb begin
      alu_res = '0;
      alu_ill = 1'b0;
      case (alu_ctrl)
         ALU_AND: alu_res = op_a & op_b;
         ALU_OR:  alu_res = op_a | op_b;
         ALU_ADD: alu_res = op_a + op_b;
         ALU_SUB: alu_res = op_a - op_b;
         ALU_SLT: alu_res = {{(XLEN-1){1'b0}},
                     ($signed(op_a) < $signed(op_b))};
         ALU_MUL: alu_res = '0;
         default: alu_ill = 1'b1;
      endcase
   end

   // Flush suppresses the pulse but leaves result/zero intact.
   always_ff @(posedge clk) begin
      if (reset) begin
         result     <= '0;
         zero       <= 1'b0;
         out_valid  <= 1'b0;
         illegal_op <= 1'b0;
      end else begin
         out_valid  <= 1'b0;
         illegal_op <= 1'b0;
         if (accept && !is_mul) begin
            result     <= alu_res;
            zero       <= (alu_res == '0);
            out_valid  <= 1'b1;
            illegal_op <= alu_ill;
         end else if (mul_done) begin
            result     <= mul_prod;
            zero       <= (mul_prod == '0);
            out_valid  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table,
// hand-written multi-cycle sequences and random ops.
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_ctrl;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        flush;
   logic        out_valid;
   logic [31:0] result;
   logic        zero;
   logic        illegal_op;
   logic        stall;

   int checks = 0;
   int fails  = 0;

   logic [31:0] last_res;
   logic        last_zero;

   alu_exec_unit #(.XLEN(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .alu_ctrl   (alu_ctrl),
      .op_a       (op_a),
      .op_b       (op_b),
      .flush      (flush),
      .out_valid  (out_valid),
      .result     (result),
      .zero       (zero),
      .illegal_op (illegal_op),
      .stall      (stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        zero;
      logic        ill;
   } vec_t;

   vec_t tbl[12];

   task automatic check(input string name,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: spec rules in plain arithmetic.
   function automatic logic [32:0] model(
      input logic [3:0] c,
      input logic [31:0] a,
      input logic [31:0] b);
      logic [63:0] p;
      p = {32'b0, a} * {32'b0, b};
      case (c)
         4'b0000: return {1'b0, a & b};
         4'b0001: return {1'b0, a | b};
         4'b0010: return {1'b0, a + b};
         4'b0110: return {1'b0, a - b};
         4'b0111: return {1'b0,
            32'(($signed(a) < $signed(b)) ? 1 : 0)};
         4'b1000: return {1'b0, p[31:0]};
         default: return {1'b1, 32'h0};
      endcase
   endfunction

   task automatic run_op(input string name,
                         input logic [3:0] c,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] exp_res,
                         input logic exp_zero,
                         input logic exp_ill);
      int lat;
      int exp_lat;
      exp_lat = (c == 4'b1000) ? 33 : 1;
      check({name, ".ready"}, 64'(in_ready), 64'd1);
      alu_ctrl = c;
      op_a     = a;
      op_b     = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 45) begin
         tick();
         lat++;
      end
      check({name, ".valid"}, 64'(out_valid), 64'd1);
      check({name, ".lat"}, 64'(lat), 64'(exp_lat));
      check({name, ".res"}, 64'(result), 64'(exp_res));
      check({name, ".zero"}, 64'(zero), 64'(exp_zero));
      check({name, ".ill"}, 64'(illegal_op), 64'(exp_ill));
      last_res  = exp_res;
      last_zero = exp_zero;
      tick();
      check({name, ".pulse"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      logic [32:0] m;
      logic [3:0]  codes[8];
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      int          seen;

      tbl[0]  = '{4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0};
      tbl[1]  = '{4'b0110, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0};
      tbl[2]  = '{4'b0111, 32'hFFFFFFFF, 32'd1,
                  32'd1, 1'b0, 1'b0};
      tbl[3]  = '{4'b0111, 32'd1, 32'hFFFFFFFF,
                  32'd0, 1'b1, 1'b0};
      tbl[4]  = '{4'b0000, 32'hF0F0_1234, 32'h0FF0_00FF,
                  32'h00F0_0034, 1'b0, 1'b0};
      tbl[5]  = '{4'b0001, 32'hF000_0000, 32'h0000_000F,
                  32'hF000_000F, 1'b0, 1'b0};
      tbl[6]  = '{4'b0010, 32'hFFFFFFFF, 32'd1,
                  32'd0, 1'b1, 1'b0};
      tbl[7]  = '{4'b0110, 32'd0, 32'd1,
                  32'hFFFFFFFF, 1'b0, 1'b0};
      tbl[8]  = '{4'b1000, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0};
      tbl[9]  = '{4'b1000, 32'hFFFFFFFF, 32'd2,
                  32'hFFFFFFFE, 1'b0, 1'b0};
      tbl[10] = '{4'b0101, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1};
      tbl[11] = '{4'b1000, 32'h1234, 32'd0, 32'd0, 1'b1, 1'b0};

      reset    = 1'b1;
      in_valid = 1'b0;
      alu_ctrl = 4'b0;
      op_a     = '0;
      op_b     = '0;
      flush    = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      check("rst.ready", 64'(in_ready), 64'd1);
      check("rst.stall", 64'(stall), 64'd0);
      check("rst.valid", 64'(out_valid), 64'd0);
      check("rst.res", 64'(result), 64'd0);
      check("rst.zero", 64'(zero), 64'd0);
      check("rst.ill", 64'(illegal_op), 64'd0);

      for (int i = 0; i < 12; i++)
         run_op($sformatf("vec%0d", i), tbl[i].ctrl,
                tbl[i].a, tbl[i].b, tbl[i].res,
                tbl[i].zero, tbl[i].ill);

      // Back-to-back single-cycle ops.
      alu_ctrl = 4'b0010; op_a = 32'd5; op_b = 32'd7;
      in_valid = 1'b1;
      tick();
      alu_ctrl = 4'b0110; op_a = 32'd3; op_b = 32'd3;
      check("b2b.v1", 64'(out_valid), 64'd1);
      check("b2b.r1", 64'(result), 64'd12);
      check("b2b.z1", 64'(zero), 64'd0);
      tick();
      in_valid = 1'b0;
      check("b2b.v2", 64'(out_valid), 64'd1);
      check("b2b.r2", 64'(result), 64'd0);
      check("b2b.z2", 64'(zero), 64'd1);
      tick();

      // ADD held throughout a MUL is taken only at T+33.
      alu_ctrl = 4'b1000; op_a = 32'd6; op_b = 32'd7;
      in_valid = 1'b1;
      tick();
      alu_ctrl = 4'b0010; op_a = 32'd10; op_b = 32'd20;
      for (int k = 1; k <= 32; k++) begin
         check($sformatf("hold.rdy%0d", k),
               64'(in_ready), 64'd0);
         check($sformatf("hold.stl%0d", k),
               64'(stall), 64'd1);
         check($sformatf("hold.ov%0d", k),
               64'(out_valid), 64'd0);
         tick();
      end
      check("hold.v33", 64'(out_valid), 64'd1);
      check("hold.r33", 64'(result), 64'd42);
      check("hold.rdy33", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      check("hold.v34", 64'(out_valid), 64'd1);
      check("hold.r34", 64'(result), 64'd30);
      last_res = 32'd30;
      tick();

      // Flush during MUL at T+10.
      alu_ctrl = 4'b1000; op_a = 32'd9; op_b = 32'd9;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 1; k < 10; k++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl.ready", 64'(in_ready), 64'd1);
      check("fl.stall", 64'(stall), 64'd0);
      check("fl.res", 64'(result), 64'(last_res));
      seen = 0;
      for (int k = 0; k < 30; k++) begin
         if (out_valid) seen++;
         tick();
      end
      check("fl.noval", 64'(seen), 64'd0);
      run_op("fl.add", 4'b0010, 32'd1, 32'd1,
             32'd2, 1'b0, 1'b0);

      // Flush in IDLE blocks acceptance.
      alu_ctrl = 4'b0010; op_a = 32'd4; op_b = 32'd4;
      in_valid = 1'b1;
      flush    = 1'b1;
      tick();
      in_valid = 1'b0;
      flush    = 1'b0;
      check("fli.valid", 64'(out_valid), 64'd0);
      check("fli.res", 64'(result), 64'd2);

      // Reset at T+5 of a MUL.
      alu_ctrl = 4'b1000; op_a = 32'd3; op_b = 32'd5;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 1; k < 5; k++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mr.ready", 64'(in_ready), 64'd1);
      check("mr.stall", 64'(stall), 64'd0);
      check("mr.res", 64'(result), 64'd0);
      check("mr.zero", 64'(zero), 64'd0);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         if (out_valid) seen++;
         tick();
      end
      check("mr.noval", 64'(seen), 64'd0);

      // Random ops against the reference model.
      codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                4'b0111, 4'b1000, 4'b0011, 4'b1111};
      for (int i = 0; i < 40; i++) begin
         c = codes[$urandom_range(7)];
         a = $urandom;
         b = $urandom;
         if (i % 7 == 0) b = a;
         m = model(c, a, b);
         run_op($sformatf("rnd%0d", i), c, a, b,
                m[31:0], (m[31:0] == 0), m[32]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage datapath that consumes the 4-bit ALU control code produced by the ALU decoder, plus two operands, and returns a registered result with a zero flag. Single-cycle ops (AND/OR/ADD/SUB/SLT) complete in one cycle. A new MUL code runs an iterative shift-add multiplier. While MUL runs, the block drives a stall to the hazard unit.

Parameters:
XLEN, 32, operand/result width
MUL_STEPS, XLEN, multiplier iterations (one bit of op_b per step)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  operation presented this cycle
in_ready  out  1  block can accept; high only in IDLE
alu_ctrl  in  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1000 MUL (low XLEN bits)
op_a  in  XLEN  operand A
op_b  in  XLEN  operand B
flush  in  1  pipeline flush; aborts in-flight op
out_valid  out  1  one-cycle pulse, result valid
result  out  XLEN  registered result, held until next out_valid
zero  out  1  registered (result == 0), updated with result
illegal_op  out  1  one-cycle pulse with out_valid for undefined alu_ctrl
stall  out  1  high while MUL in progress (state != IDLE)

Behaviour:
- Reset (sync, active-high): state IDLE, step counter 0, result 0, zero 0, out_valid 0, illegal_op 0. in_ready=1 and stall=0 combinationally from IDLE. Reset mid-MUL discards the operation; no out_valid follows.
- Accept: an operation is accepted at rising edge T when in_valid && in_ready && !flush.
- Single-cycle ops: result, zero and out_valid register at edge T and are visible in cycle T+1.
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT gives 1 if $signed(op_a) < $signed(op_b), else 0.
- Undefined alu_ctrl: result 0, zero 1, out_valid and illegal_op pulse at T+1.
- States: IDLE, MUL_RUN.
  - IDLE -> MUL_RUN on accepting MUL. At edge T: load multiplicand=op_a, multiplier=op_b, acc=0, count=0.
  - MUL_RUN, each edge: if multiplier[0], acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; count++.
  - When count reaches MUL_STEPS-1 on the step edge: result=acc (including that final step), zero updated, out_valid pulses, state -> IDLE.
  - For XLEN=32: steps at edges T+1..T+32; out_valid visible in cycle T+33. in_ready=0 and stall=1 in cycles T+1..T+32. in_ready=1 from cycle T+33.
- No early termination on a zero multiplier; latency is fixed.
- Operations offered while busy are ignored. The upstream stage must hold them (stall).
- Flush:
  - In MUL_RUN: go to IDLE at that edge, discard acc, no out_valid.
  - In IDLE: nothing is accepted that edge.
  - Always: out_valid/illegal_op forced 0 at that edge. result and zero keep their prior values.
- flush and reset together: reset wins (identical outcome).
- out_valid has no backpressure. Downstream always consumes it.
- Back-to-back single-cycle ops: one accepted per cycle, out_valid high on consecutive cycles.

Decomposition:
- Shared package alu_pkg holds:
  - ALU control code constants (AND/OR/ADD/SUB/SLT/MUL), also imported by the ALU decoder so both ends agree.
  - The state enum (IDLE, MUL_RUN).
- Natural sub-module: seq_multiplier, the shift-add datapath and step counter. Interface: start, flush, op_a, op_b, done, product.

Test Plan:
- ADD op_a=5, op_b=7 accepted at T -> out_valid in T+1, result=12, zero=0; SUB 3-3 next cycle -> result=0, zero=1 at T+2.
- SLT op_a=0xFFFFFFFF, op_b=1 -> result=1; op_a=1, op_b=0xFFFFFFFF -> result=0.
- MUL 6*7 at T -> in_ready=0 and stall=1 for T+1..T+32; out_valid only in T+33, result=42. MUL 0xFFFFFFFF*2 -> result=0xFFFFFFFE.
- MUL accepted, flush at T+10 -> no out_valid through T+40, in_ready=1 from T+11, result keeps prior value; next ADD 1+1 -> 2 one cycle later.
- in_valid held with ADD throughout a MUL -> ADD accepted only at the cycle-T+33 edge, result=sum in T+34.
- alu_ctrl=0101 -> out_valid and illegal_op pulse, result=0, zero=1. Reset at T+5 of a MUL -> all outputs at reset values, no late out_valid.
